// File: rtl/alu_muldiv_seq.sv
// Clocked integer ALU with registered icc flags, a Y register and SPARC-style iterative multiply/divide.
// Build option ALU_FAST_MUL_EN: multiplies use a combinational multiplier and complete in one cycle.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// RUN   | iterative multiply/divide step per cycle, busy=1
// FIN   | iterative result valid (done=1); a new start is accepted
module alu_muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       alu_operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             y_we,
   input  logic [WIDTH-1:0] y_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] alu_output,
   output logic [WIDTH-1:0] y_out,
   output logic             N_flag,
   output logic             Z_flag,
   output logic             V_flag,
   output logic             C_flag,
   output logic             dz_err
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   res_q, y_q, hi_q, lo_q, opnd_q;
   logic               n_q, z_q, v_q, c_q;
   logic               done_q, dz_q;
   logic               is_div_q, sgn_q, cc_q, neg_q, ovf_q;

   // single-cycle datapath
   logic               cin, sgn;
   logic [WIDTH:0]     add_full, sub_full;
   logic [WIDTH-1:0]   sc_res, sc_y;
   logic               sc_v, sc_c, sc_cc, sc_ywe, sc_dz;
   logic               is_mul, is_div, iter_op;

   assign cin      = alu_operation[3] & c_q;
   assign sgn      = alu_operation[0];
   assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

`ifdef ALU_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
   assign ext_a     = {{WIDTH{sgn & a[MSB]}}, a};
   assign ext_b     = {{WIDTH{sgn & b[MSB]}}, b};
   assign fast_prod = ext_a * ext_b;
`endif

   always_comb begin
      sc_res = '0;
      sc_y   = '0;
      sc_v   = 1'b0;
      sc_c   = 1'b0;
      sc_cc  = 1'b0;
      sc_ywe = 1'b0;
      sc_dz  = 1'b0;
      is_mul = 1'b0;
      is_div = 1'b0;
      if (!alu_operation[5]) begin
         sc_cc = alu_operation[4];
         case (alu_operation[3:0])
            4'b0000, 4'b1000: begin
               sc_res = add_full[MSB:0];
               sc_c   = add_full[WIDTH];
               sc_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
            end
            4'b0100, 4'b1100: begin
               sc_res = sub_full[MSB:0];
               sc_c   = sub_full[WIDTH];
               sc_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
            end
            4'b0001: sc_res = a & b;
            4'b0101: sc_res = a & ~b;
            4'b0010: sc_res = a | b;
            4'b0110: sc_res = a | ~b;
            4'b0011: sc_res = a ^ b;
            4'b0111: sc_res = ~(a ^ b);
            4'b1010, 4'b1011: begin
               is_mul = 1'b1;
`ifdef ALU_FAST_MUL_EN
               sc_res = fast_prod[MSB:0];
               sc_y   = fast_prod[2*WIDTH-1:WIDTH];
               sc_ywe = 1'b1;
`endif
            end
            4'b1110, 4'b1111: begin
               // only reaches the single-cycle path when b==0
               is_div = 1'b1;
               sc_res = '1;
               sc_cc  = 1'b0;
               sc_dz  = 1'b1;
            end
            default: sc_cc = 1'b0;
         endcase
      end else begin
         case (alu_operation[4:0])
            5'b00101: sc_res = a << b[SHW-1:0];
            5'b00110: sc_res = a >> b[SHW-1:0];
            5'b00111: sc_res = WIDTH'($signed(a) >>> b[SHW-1:0]);
            default:  sc_res = '0;
         endcase
      end
   end

`ifdef ALU_FAST_MUL_EN
   assign iter_op = is_div && (b != '0);
`else
   assign iter_op = (is_div && (b != '0)) || is_mul;
`endif

   // operand preparation at launch: magnitudes for signed ops, sign fixed at the end
   logic [2*WIDTH-1:0] dvd, dvd_mag;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               ld_neg, ld_ovf;

   assign a_mag   = (sgn && a[MSB]) ? -a : a;
   assign b_mag   = (sgn && b[MSB]) ? -b : b;
   assign dvd     = {y_q, a};
   assign dvd_mag = (sgn && y_q[MSB]) ? -dvd : dvd;
   assign ld_neg  = sgn & ((is_div ? y_q[MSB] : a[MSB]) ^ b[MSB]);
   assign ld_ovf  = dvd_mag[2*WIDTH-1:WIDTH] >= b_mag;

   // one iteration step
   logic [WIDTH:0]     mul_sum, div_sh;
   logic [WIDTH-1:0]   div_r, step_hi, step_lo;
   logic               div_ge;

   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_sh  = {hi_q, lo_q[MSB]};
   assign div_ge  = div_sh >= {1'b0, opnd_q};
   assign div_r   = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[MSB:0];
   assign step_hi = is_div_q ? div_r : mul_sum[WIDTH:1];
   assign step_lo = is_div_q ? {lo_q[MSB-1:0], div_ge} : {mul_sum[0], lo_q[MSB:1]};

   // final result of an iterative op, formed from the last step
   logic [2*WIDTH-1:0] prod, prod_f;
   logic [WIDTH-1:0]   lim, fin_res;
   logic               fin_v;

   assign prod   = {step_hi, step_lo};
   assign prod_f = neg_q ? -prod : prod;
   // largest signed quotient magnitude; also the saturation value
   assign lim    = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

   always_comb begin
      fin_res = prod_f[MSB:0];
      fin_v   = 1'b0;
      if (is_div_q) begin
         if (sgn_q) begin
            if (ovf_q || (step_lo > lim)) begin
               fin_res = lim;
               fin_v   = 1'b1;
            end else begin
               fin_res = neg_q ? -step_lo : step_lo;
            end
         end else if (ovf_q) begin
            fin_res = '1;
            fin_v   = 1'b1;
         end else begin
            fin_res = step_lo;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_FIN: state_d = (start && iter_op) ? S_RUN : S_IDLE;
         S_RUN:         if (cnt_q == '0) state_d = S_FIN;
         default:       state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         res_q    <= '0;
         y_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         {n_q, z_q, v_q, c_q} <= 4'b0000;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         is_div_q <= 1'b0;
         sgn_q    <= 1'b0;
         cc_q     <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         if (y_we && (state_q != S_RUN)) y_q <= y_in;
         if (state_q == S_RUN) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
               done_q <= 1'b1;
               res_q  <= fin_res;
               if (!is_div_q) y_q <= prod_f[2*WIDTH-1:WIDTH];
               if (cc_q) {n_q, z_q, v_q, c_q} <= {fin_res[MSB], fin_res == '0, fin_v, 1'b0};
            end
         end else if (start) begin
            if (iter_op) begin
               cnt_q    <= '1;
               is_div_q <= !is_mul;
               sgn_q    <= sgn;
               cc_q     <= alu_operation[4];
               neg_q    <= ld_neg;
               ovf_q    <= is_div ? ld_ovf : 1'b0;
               opnd_q   <= b_mag;
               hi_q     <= is_div ? dvd_mag[2*WIDTH-1:WIDTH] : '0;
               lo_q     <= is_div ? dvd_mag[MSB:0] : a_mag;
            end else begin
               done_q <= 1'b1;
               dz_q   <= sc_dz;
               res_q  <= sc_res;
               if (sc_ywe) y_q <= sc_y;
               if (sc_cc) {n_q, z_q, v_q, c_q} <= {sc_res[MSB], sc_res == '0, sc_v, sc_c};
            end
         end
      end
   end

   assign busy       = (state_q == S_RUN);
   assign done       = done_q;
   assign dz_err     = dz_q;
   assign alu_output = res_q;
   assign y_out      = y_q;
   assign N_flag     = n_q;
   assign Z_flag     = z_q;
   assign V_flag     = v_q;
   assign C_flag     = c_q;

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, clocked successor to the combinational integer ALU.
- Executes the same add/sub/logic/shift opcode set in one registered cycle.
- Adds iterative SPARC-style multiply and divide using a Y register.
- Holds the icc flags (N, Z, V, C) in registers, updated only by cc-variant ops; sits in the execute stage and stalls the pipeline via busy.

Parameters:
- WIDTH, 32: operand, result and Y width (power of two, >= 8).
- SHW, 5: shift-amount width, equal to log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  launches op; sampled only when busy=0.
- alu_operation  in  6  opcode.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2|simm operand.
- y_we  in  1  write Y (WRY).
- y_in  in  WIDTH  Y write data.
- busy  out  1  iterative op in flight.
- done  out  1  one-cycle pulse; result valid.
- alu_output  out  WIDTH  result, held until the next done.
- y_out  out  WIDTH  Y register.
- N_flag, Z_flag, V_flag, C_flag  out  1 each  registered icc.
- dz_err  out  1  one-cycle pulse with done on divide by zero.

Behaviour:
- Reset: alu_output=0, y_out=0, icc=0, busy=0, done=0, dz_err=0. Reset mid-operation aborts the op with no done and no state update.
- The C_flag register also serves as the carry input for addx/subx.
- Single-cycle ops use the existing encodings:
  - add/addcc 000000/010000, addx/addxcc 001000/011000
  - sub/subcc 000100/010100, subx/subxcc 001100/011100
  - and/andn/or/orn/xor/xorn 0000x1..000111, with cc variants at 01xxxx
  - sll/srl/sra 100101/100110/100111, shift amount b[SHW-1:0]; sra is arithmetic.
- Single-cycle latency: start at edge k gives done=1 with alu_output valid after edge k+1.
- Flags on cc ops:
  - N = msb of result; Z = (result==0).
  - add: C = carry-out of WIDTH bits; V = signed overflow.
  - sub: C = borrow; V = signed overflow.
  - logic: C=0, V=0.
  - Non-cc ops leave icc unchanged.
- Iterative multiply ops: umul 001010, smul 001011, umulcc 011010, smulcc 011011.
  - Radix-2 shift-add; smul takes operand magnitudes and fixes the sign at the end.
  - busy=1 for WIDTH cycles, then done.
  - Product of 2*WIDTH bits: alu_output = low half, Y = high half.
  - cc variants: N, Z from the low half; V=0, C=0.
- Iterative divide ops: udiv 001110, sdiv 001111, udivcc 011110, sdivcc 011111.
  - Dividend is {Y, a} (2*WIDTH bits), divisor is b; restoring division, WIDTH cycles; Y unchanged.
  - Quotient overflow: udiv saturates to all ones; sdiv saturates to max positive or min negative per sign. V=1 on overflow for cc variants, else V=0; C=0.
  - b==0: no iteration; done the next cycle with alu_output=all ones, dz_err=1, icc unchanged.
- Handshake and sequencing:
  - FSM: IDLE -> (start & iterative op) -> RUN, with a counter counting WIDTH-1 down to 0 -> FIN (done=1) -> IDLE.
  - Operands are latched at start, so a and b may change while busy.
  - start while busy is ignored; start in the FIN cycle is accepted (back-to-back).
  - y_we while busy is ignored; y_we with start=0 and busy=0 loads Y next cycle.
  - y_we together with start: the op uses the old Y, then the Y write takes effect; the multiply write of Y wins if both land on the same edge.
  - Undefined opcode: done next cycle, alu_output=0, icc and Y unchanged.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: multiply ops use a combinational WIDTH x WIDTH multiplier and behave as single-cycle ops (done after 1 cycle, busy never asserted).
- Undefined: multiply ops are iterative (WIDTH cycles). Divide is iterative in both builds; results and flags are identical in both builds.

Test Plan:
- addcc a=32'h7FFFFFFF, b=1 -> alu_output=32'h80000000, N=1, Z=0, V=1, C=0, done 1 cycle after start.
- subcc a=0, b=1, then subx a=5, b=2 -> first: 32'hFFFFFFFF, C=1, N=1; second: 2 (uses C=1).
- smul a=-3, b=7 -> alu_output=32'hFFFFFFEB, Y=32'hFFFFFFFF, busy for 32 cycles, done on the 33rd edge (1 cycle with ALU_FAST_MUL_EN).
- WRY y_in=0, then udivcc a=100, b=7 -> alu_output=14, V=0; then Y=1, udivcc a=0, b=1 -> alu_output=32'hFFFFFFFF, V=1.
- sdiv b=0 -> dz_err=1 and done next cycle, alu_output=32'hFFFFFFFF, icc unchanged.
- reset asserted at cycle 10 of a udiv -> busy=0, no done, all outputs 0; a following add 2+3 -> 5.
